tc_timer: RTL and testbench

Memory-mapped countdown timer that responds to the MEM-stage store/load bus. The CPU side resolves the address, issues word stores with byte enables, and filters illegal timer accesses. This block decodes the register offset, applies writes, returns read data, and runs the countdown FSM that raises the hardware interrupt. Two instances sit behind the bridge: base 0x0000_7F00 and base 0x0000_7F10.

---
 rtl/tc_pkg.sv | 41 ++++
 rtl/tc_timer.sv | 133 +++++++++++++
 tb/tb_tc_timer.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tc_pkg.sv
// tc_pkg: shared definitions for the tc_timer register block and countdown FSM.
// Register offsets, CTRL bit positions, mode encodings, FSM state encoding and
// a byte-lane merge helper used by the store path.
package tc_pkg;

   // Word offsets (bridge address bits [3:2])
   localparam logic [1:0] TC_CTRL   = 2'b00;
   localparam logic [1:0] TC_PRESET = 2'b01;
   localparam logic [1:0] TC_COUNT  = 2'b10;

   // CTRL bit positions; only CTRL[3:0] is implemented
   localparam int unsigned CTRL_EN      = 0;
   localparam int unsigned CTRL_MODE_LO = 1;
   localparam int unsigned CTRL_MODE_HI = 2;
   localparam int unsigned CTRL_IM      = 3;
   localparam int unsigned CTRL_W       = 4;

   // Mode encodings; 2'b10 and 2'b11 fall back to one-shot behaviour
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_AUTO    = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_CNT  = 2'b10,
      ST_INT  = 2'b11
   } tc_state_e;

   // Replace each byte of old_val whose lane bit is set with the matching byte of new_val
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_val;
      for (int unsigned i = 0; i < 4; i++) begin
         if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/tc_timer.sv
// tc_timer: memory-mapped countdown timer (CTRL / PRESET / COUNT) with
// one-shot and auto-reload modes and a registered, maskable interrupt.
// Build option: define TC_BYTE_WRITE_EN to allow per-byte-lane stores;
// otherwise only full-word stores (be = 4'b1111) are applied.
module tc_timer
   import tc_pkg::*;
#(
   parameter logic [31:0] RST_PRESET = 32'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  addr,
   input  logic        we,
   input  logic [3:0]  be,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        irq
);

   logic [CTRL_W-1:0] ctrl_q;
   logic [CTRL_W-1:0] ctrl_d;
   logic [31:0]       preset_q;
   logic [31:0]       count_q;
   tc_state_e         state_q;
   tc_state_e         state_d;
   logic              irq_flag;
   logic              flag_pulse;
   logic              wr_accept;
   logic              ctrl_wr;
   logic              preset_wr;
   logic              mode_auto;
   logic              do_load;
   logic              do_step;
   logic              at_int;

   // Store acceptance: byte-lane mode takes any non-empty store, word mode needs all lanes
   always_comb begin
`ifdef TC_BYTE_WRITE_EN
      wr_accept = we && (be != 4'b0000);
`else
      wr_accept = we && (be == 4'b1111);
`endif
      ctrl_wr   = wr_accept && (addr == TC_CTRL);
      preset_wr = wr_accept && (addr == TC_PRESET);
      mode_auto = (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_AUTO);
   end

   // Next CTRL value; the FSM sees this value so a write acts on the same edge.
   // A bus write overrides the one-shot auto-clear of en at INT.
   always_comb begin
      ctrl_d = ctrl_q;
      if (at_int && !mode_auto) ctrl_d[CTRL_EN] = 1'b0;
      if (ctrl_wr && be[0]) ctrl_d = wdata[CTRL_W-1:0];
   end

   // CTRL and PRESET registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_q   <= '0;
         preset_q <= RST_PRESET;
      end else begin
         ctrl_q <= ctrl_d;
         if (preset_wr) preset_q <= merge_bytes(preset_q, wdata, be);
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (ctrl_d[CTRL_EN]) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_CNT;
         ST_CNT: begin
            if (!ctrl_d[CTRL_EN])        state_d = ST_IDLE;
            else if (count_q <= 32'd1)   state_d = ST_INT;
         end
         ST_INT:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM outputs and read-data mux
   always_comb begin
      do_load = (state_q == ST_LOAD);
      do_step = (state_q == ST_CNT) && ctrl_d[CTRL_EN];
      at_int  = (state_q == ST_INT);
      rdata   = '0;
      case (addr)
         TC_CTRL:   rdata = {{(32-CTRL_W){1'b0}}, ctrl_q};
         TC_PRESET: rdata = preset_q;
         TC_COUNT:  rdata = count_q;
         default:   rdata = '0;
      endcase
   end

   // COUNT: load from PRESET, then count down and saturate at zero
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count_q <= '0;
      end else if (do_load) begin
         count_q <= preset_q;
      end else if (do_step) begin
         count_q <= (count_q > 32'd1) ? count_q - 32'd1 : '0;
      end
   end

   // Interrupt flag: sticky in one-shot until a CTRL write, single cycle in auto-reload
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_flag   <= 1'b0;
         flag_pulse <= 1'b0;
      end else if (at_int) begin
         irq_flag   <= 1'b1;
         flag_pulse <= mode_auto;
      end else if (ctrl_wr || flag_pulse) begin
         irq_flag   <= 1'b0;
         flag_pulse <= 1'b0;
      end
   end

   // Registered, masked interrupt output
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) irq <= 1'b0;
      else          irq <= irq_flag & ctrl_q[CTRL_IM];
   end

endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: directed scenario tasks plus a randomized run checked against an
// edge-indexed behavioural model of the timer.
module tb_tc_timer;

   localparam logic [31:0] RP       = 32'h0000_0010;
   localparam logic [1:0]  A_CTRL   = 2'b00;
   localparam logic [1:0]  A_PRESET = 2'b01;
   localparam logic [1:0]  A_COUNT  = 2'b10;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  addr = 2'b00;
   logic        we = 1'b0;
   logic [3:0]  be = 4'h0;
   logic [31:0] wdata = '0;
   logic [31:0] rdata;
   logic        irq;

   int total = 0;
   int bad   = 0;

   tc_timer #(.RST_PRESET(RP)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .addr    (addr),
      .we      (we),
      .be      (be),
      .wdata   (wdata),
      .rdata   (rdata),
      .irq     (irq)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   // The timer is described by edge indices: m_start is the edge at which en
   // was seen, LOAD is m_start+1, COUNT = max(P-(k-1),0) for edge k after start,
   // and the interrupt edge is start + max(P,1) + 2.
   longint      m_edge, m_start;
   logic [3:0]  m_ctrl;
   logic [31:0] m_preset, m_count, m_load;
   logic        m_flag, m_pulse, m_irq;

   longint      c_now, c_k, c_len;
   logic        c_ok, c_cw, c_pw, c_int, c_auto;
   logic [3:0]  c_ctrl;
   logic [31:0] c_preset;

   // Values the model derives for the coming edge
   always_comb begin
      c_now = m_edge + 1;
      c_k   = c_now - m_start;
      c_len = (m_load == 32'd0) ? 64'sd1 : longint'(m_load);
`ifdef TC_BYTE_WRITE_EN
      c_ok = we && (be != 4'h0);
`else
      c_ok = we && (be == 4'hF);
`endif
      c_cw   = c_ok && (addr == A_CTRL);
      c_pw   = c_ok && (addr == A_PRESET);
      c_int  = (m_start >= 0) && (c_k == c_len + 2);
      c_auto = (m_ctrl[2:1] == 2'b01);
      c_ctrl = m_ctrl;
      if (c_int && !c_auto) c_ctrl[0] = 1'b0;
      if (c_cw && be[0]) c_ctrl = wdata[3:0];
      c_preset = m_preset;
      if (c_pw) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) c_preset[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   // Model state update on each clock edge or async reset
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_edge   <= 0;
         m_start  <= -1;
         m_ctrl   <= '0;
         m_preset <= RP;
         m_count  <= '0;
         m_load   <= '0;
         m_flag   <= 1'b0;
         m_pulse  <= 1'b0;
         m_irq    <= 1'b0;
      end else begin
         m_edge   <= c_now;
         m_ctrl   <= c_ctrl;
         m_preset <= c_preset;
         m_irq    <= m_flag & m_ctrl[3];
         if (c_int) begin
            m_flag  <= 1'b1;
            m_pulse <= c_auto;
         end else if (c_cw || m_pulse) begin
            m_flag  <= 1'b0;
            m_pulse <= 1'b0;
         end
         if (m_start < 0) begin
            if (c_ctrl[0]) m_start <= c_now;
         end else if (c_k == 1) begin
            m_load  <= m_preset;
            m_count <= m_preset;
         end else if (c_int || !c_ctrl[0]) begin
            m_start <= -1;
         end else begin
            m_count <= (longint'(m_load) > c_k - 1) ? m_load - 32'(c_k - 1) : 32'd0;
         end
      end
   end

   function automatic logic [31:0] m_read(input logic [1:0] a);
      case (a)
         A_CTRL:   return {28'd0, m_ctrl};
         A_PRESET: return m_preset;
         A_COUNT:  return m_count;
         default:  return 32'd0;
      endcase
   endfunction

   // ---------------- bus helpers ----------------
   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [3:0] lanes, input logic [31:0] d);
      addr  = a;
      be    = lanes;
      wdata = d;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we = 1'b0;
      be = 4'h0;
   endtask

   task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = rdata;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      logic [31:0] exp_v [4];
      logic [31:0] d;
      exp_v = '{32'h0, RP, 32'h0, 32'h0};
      reset_n = 1'b0;
      step(3);
      reset_n = 1'b1;
      step(2);
      for (int i = 0; i < 4; i++) begin
         read_reg(2'(i), d);
         total++;
         if (d !== exp_v[i]) begin
            bad++;
            $display("FAIL reset_read[%0d]: got %08h expected %08h", i, d, exp_v[i]);
         end
      end
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL reset_irq: got %b expected 0", irq);
      end
   endtask

   task automatic test_one_shot();
      int rise;
      logic [31:0] d;
      rise = -1;
      bus_write(A_PRESET, 4'hF, 32'd5);
      bus_write(A_CTRL, 4'hF, 32'h9);
      for (int i = 1; i <= 20 && rise < 0; i++) begin
         step(1);
         if (irq === 1'b1) rise = i;
      end
      total++;
      if (rise != 8) begin
         bad++;
         $display("FAIL oneshot_latency: got %0d expected 8", rise);
      end
      read_reg(A_CTRL, d);
      total++;
      if (d !== 32'h8) begin
         bad++;
         $display("FAIL oneshot_ctrl: got %08h expected 00000008", d);
      end
      step(3);
      total++;
      if (irq !== 1'b1) begin
         bad++;
         $display("FAIL oneshot_sticky: got %b expected 1", irq);
      end
      bus_write(A_CTRL, 4'hF, 32'h0);
      step(1);
      total++;
      if (irq !== 1'b0) begin
         bad++;
         $display("FAIL oneshot_clear: got %b expected 0", irq);
      end
   endtask

   task automatic test_auto_reload();
      logic        e_irq;
      logic [31:0] e_cnt;
      int          j;
      bus_write(A_PRESET, 4'hF, 32'd3);
      bus_write(A_CTRL, 4'hF, 32'hB);
      addr = A_COUNT;
      for (int i = 1; i <= 24; i++) begin
         step(1);
         e_irq = ((i % 6) == 0);
         j     = (i - 1) % 6;
         e_cnt = (j < 3) ? 32'(3 - j) : 32'd0;
         total++;
         if (irq !== e_irq) begin
            bad++;
            $display("FAIL auto_irq[%0d]: got %b expected %b", i, irq, e_irq);
         end
         total++;
         if (rdata !== e_cnt) begin
            bad++;
            $display("FAIL auto_count[%0d]: got %0d expected %0d", i, rdata, e_cnt);
         end
      end
      bus_write(A_CTRL, 4'hF, 32'h0);
      step(4);
   endtask

   task automatic test_mask();
      logic        seen;
      logic [31:0] d;
      seen = 1'b0;
      bus_write(A_PRESET, 4'hF, 32'd2);
      bus_write(A_CTRL, 4'hF, 32'h1);
      for (int i = 0; i < 10; i++) begin
         step(1);
         if (irq !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL mask_irq: got 1 expected 0");
      end
      read_reg(A_COUNT, d);
      total++;
      if (d !== 32'd0) begin
         bad++;
         $display("FAIL mask_count: got %0d expected 0", d);
      end
      bus_write(A_CTRL, 4'hF, 32'h8);
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         if (irq !== 1'b0) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0) begin
         bad++;
         $display("FAIL mask_unmask: got 1 expected 0");
      end
      bus_write(A_CTRL, 4'hF, 32'h0);
   endtask

   task automatic test_writes_during_count();
      logic [31:0] d;
      bus_write(A_PRESET, 4'hF, 32'd20);
      bus_write(A_CTRL, 4'hF, 32'h1);
      step(3);
      bus_write(A_COUNT, 4'hF, 32'h0000_FFFF);
      read_reg(A_COUNT, d);
      total++;
      if (d !== 32'd17) begin
         bad++;
         $display("FAIL wcnt_count_write: got %0d expected 17", d);
      end
      bus_write(A_PRESET, 4'hF, 32'd9);
      read_reg(A_COUNT, d);
      total++;
      if (d !== 32'd16) begin
         bad++;
         $display("FAIL wcnt_preset_nofx: got %0d expected 16", d);
      end
      bus_write(A_CTRL, 4'hF, 32'h0);
      step(3);
      read_reg(A_COUNT, d);
      total++;
      if (d !== 32'd16) begin
         bad++;
         $display("FAIL wcnt_freeze: got %0d expected 16", d);
      end
      bus_write(A_CTRL, 4'hF, 32'h1);
      step(1);
      read_reg(A_COUNT, d);
      total++;
      if (d !== 32'd9) begin
         bad++;
         $display("FAIL wcnt_reload: got %0d expected 9", d);
      end
      bus_write(A_CTRL, 4'hF, 32'h0);
      step(3);
   endtask

   task automatic test_partial_store();
      logic [31:0] d;
      logic [31:0] e_pre;
      logic [31:0] e_ctl;
`ifdef TC_BYTE_WRITE_EN
      e_pre = 32'h1234_56AB;
      e_ctl = 32'h8;
`else
      e_pre = 32'h1234_5678;
      e_ctl = 32'h0;
`endif
      bus_write(A_PRESET, 4'hF, 32'h1234_5678);
      bus_write(A_PRESET, 4'b0001, 32'h0000_00AB);
      read_reg(A_PRESET, d);
      total++;
      if (d !== e_pre) begin
         bad++;
         $display("FAIL partial_preset: got %08h expected %08h", d, e_pre);
      end
      bus_write(A_CTRL, 4'b0001, 32'h8);
      read_reg(A_CTRL, d);
      total++;
      if (d !== e_ctl) begin
         bad++;
         $display("FAIL partial_ctrl: got %08h expected %08h", d, e_ctl);
      end
      bus_write(A_CTRL, 4'hF, 32'h0);
   endtask

   task automatic test_reset_midcount();
      logic [31:0] d;
      bus_write(A_PRESET, 4'hF, 32'd50);
      bus_write(A_CTRL, 4'hF, 32'h9);
      step(5);
      #2;
      reset_n = 1'b0;
      #1;
      read_reg(A_COUNT, d);
      total++;
      if (d !== 32'd0) begin
         bad++;
         $display("FAIL arst_count: got %0d expected 0", d);
      end
      read_reg(A_CTRL, d);
      total++;
      if (d !== 32'd0) begin
         bad++;
         $display("FAIL arst_ctrl: got %08h expected 0", d);
      end
      read_reg(A_PRESET, d);
      total++;
      if (d !== RP) begin
         bad++;
         $display("FAIL arst_preset: got %08h expected %08h", d, RP);
      end
      step(2);
      reset_n = 1'b1;
      step(3);
      read_reg(A_COUNT, d);
      total++;
      if (d !== 32'd0 || irq !== 1'b0) begin
         bad++;
         $display("FAIL arst_idle: got count=%0d irq=%b expected count=0 irq=0", d, irq);
      end
   endtask

   task automatic test_random();
      logic [31:0] e;
      bus_write(A_PRESET, 4'hF, 32'd4);
      for (int c = 0; c < 400; c++) begin
         we    = ($urandom_range(0, 2) == 0);
         addr  = 2'($urandom_range(0, 3));
         be    = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         wdata = $urandom;
         if (addr == A_PRESET) wdata = 32'($urandom_range(0, 7));
         #1;
         e = m_read(addr);
         total++;
         if (rdata !== e) begin
            bad++;
            $display("FAIL rand_rdata[%0d] addr=%0d: got %08h expected %08h", c, addr, rdata, e);
         end
         @(posedge clk);
         #1;
         total++;
         if (irq !== m_irq) begin
            bad++;
            $display("FAIL rand_irq[%0d]: got %b expected %b", c, irq, m_irq);
         end
      end
      we = 1'b0;
      be = 4'h0;
   endtask

   initial begin
      test_reset();
      test_one_shot();
      test_auto_reload();
      test_mask();
      test_writes_during_count();
      test_partial_store();
      test_reset_midcount();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded its time limit");
      $fatal(1);
   end

endmodule
